// File: rtl/chain_sequencer.sv
// Timed valve sequencer: walks one slug from inlet k0 through N chambers and out of kN.
// Optional CHAIN_SEQ_STEP_EN adds a 'step' input that gates every DWELL exit.
module chain_sequencer #(
  parameter int N_CHAMBERS = 16,
  parameter int PULSE_CYC  = 4,
  parameter int DWELL_W    = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
`ifdef CHAIN_SEQ_STEP_EN
  input  logic                                step,
`endif
  input  logic [DWELL_W-1:0]                  dwell,
  output logic [N_CHAMBERS:0]                 valve,
  output logic [$clog2(N_CHAMBERS+1)-1:0]     pos,
  output logic                                busy,
  output logic                                done,
  output logic                                aborted
);

  localparam int POS_W  = $clog2(N_CHAMBERS + 1);
  localparam int PW     = $clog2(PULSE_CYC + 1);
  localparam int CNT_W  = (DWELL_W > PW) ? DWELL_W : PW;
  localparam int VW     = N_CHAMBERS + 1;

  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(N_CHAMBERS - 1);
  localparam logic [POS_W-1:0] DRAIN_POS = POS_W'(N_CHAMBERS);
  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DWELL,
    S_XFER,
    S_DONE
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DWELL_W-1:0] dwell_q_reg;
  logic [CNT_W-1:0]   dwell_ld;
  logic               cnt_zero;
  logic               dwell_go;

  assign dwell_ld = CNT_W'(dwell_q_reg) - CNT_W'(1);
  assign cnt_zero = (cnt_reg == '0);

`ifdef CHAIN_SEQ_STEP_EN
  // A step seen at any point in the current DWELL is remembered until the count expires.
  logic step_seen_reg;

  assign dwell_go = cnt_zero && (step_seen_reg || step);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_seen_reg <= 1'b0;
    end else if (state_reg != S_DWELL || dwell_go) begin
      step_seen_reg <= 1'b0;
    end else if (step) begin
      step_seen_reg <= 1'b1;
    end
  end
`else
  assign dwell_go = cnt_zero;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      dwell_q_reg <= '0;
      pos         <= '0;
      valve       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      if (abort && state_reg != S_IDLE) begin
        // Abort beats any simultaneous expiry; pos is left for the host to inspect.
        state_reg <= S_IDLE;
        cnt_reg   <= '0;
        valve     <= '0;
        busy      <= 1'b0;
        aborted   <= 1'b1;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start && !abort) begin
              state_reg   <= S_FILL;
              pos         <= '0;
              dwell_q_reg <= (dwell == '0) ? DWELL_W'(1) : dwell;
              cnt_reg     <= PULSE_LD;
              valve       <= VW'(1);
              busy        <= 1'b1;
            end
          end
          S_FILL: begin
            if (cnt_zero) begin
              state_reg <= S_DWELL;
              cnt_reg   <= dwell_ld;
              valve     <= '0;
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          S_DWELL: begin
            if (dwell_go) begin
              state_reg <= S_XFER;
              cnt_reg   <= PULSE_LD;
              valve     <= VW'(2) << pos;
            end else if (!cnt_zero) begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          S_XFER: begin
            if (cnt_zero) begin
              valve <= '0;
              if (pos == LAST_POS) begin
                state_reg <= S_DONE;
                pos       <= DRAIN_POS;
                busy      <= 1'b0;
                done      <= 1'b1;
              end else begin
                state_reg <= S_DWELL;
                pos       <= pos + POS_W'(1);
                cnt_reg   <= dwell_ld;
              end
            end else begin
              cnt_reg <= cnt_reg - CNT_W'(1);
            end
          end
          S_DONE: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
            valve     <= '0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chain_sequencer.sv
// Scoreboard bench for chain_sequencer: a timeline model predicts valve pulses, busy window
// and done/aborted pulses per run; a monitor reconstructs the same events from the DUT pins.
module tb_chain_sequencer;
  localparam int N  = 16;
  localparam int P  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [DW-1:0] dwell = '0;
  logic [N:0]    valve;
  logic [$clog2(N+1)-1:0] pos;
  logic          busy, done, aborted;
`ifdef CHAIN_SEQ_STEP_EN
  logic          step = 1'b1;
`endif

  chain_sequencer #(.N_CHAMBERS(N), .PULSE_CYC(P), .DWELL_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
`ifdef CHAIN_SEQ_STEP_EN
    .step(step),
`endif
    .dwell(dwell), .valve(valve), .pos(pos), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct packed {
    int kind;  // 0 valve pulse, 1 busy window, 2 done, 3 aborted
    int idx;
    int t0;
    int len;
    int p;
  } evt_t;

  evt_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   sb_en = 1'b0;

  function automatic string kname(input int k);
    case (k)
      0: return "valve";
      1: return "busy";
      2: return "done";
      default: return "aborted";
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic evt_t mk(input int k, input int i, input int t, input int l, input int p);
    evt_t e;
    e.kind = k; e.idx = i; e.t0 = t; e.len = l; e.p = p;
    return e;
  endfunction

  // Chamber index holding the slug at run-relative cycle e: transfer j completes at P + j*(dq+P).
  function automatic int pos_at(input int e, input int dq);
    int c = 0;
    for (int j = 1; j <= N; j++)
      if (P + j * (dq + P) <= e) c++;
    return c;
  endfunction

  // First FILL cycle observed at edge count a; abort_e<0 means the run completes.
  task automatic model_run(input int a, input int dq, input int abort_e);
    int rl, end_e, s, l;
    rl    = P + N * (dq + P);
    end_e = (abort_e < 0) ? rl : abort_e + 1;
    for (int j = 0; j <= N; j++) begin
      s = (j == 0) ? 0 : P + (j - 1) * (dq + P) + dq;
      if (s < end_e) begin
        l = (end_e - s < P) ? end_e - s : P;
        exp_q.push_back(mk(0, j, a + s, l, (j == 0) ? 0 : j - 1));
      end
    end
    exp_q.push_back(mk(1, 0, a, end_e, 0));
    if (abort_e < 0) exp_q.push_back(mk(2, 0, a + rl, 1, N));
    else             exp_q.push_back(mk(3, 0, a + end_e, 1, pos_at(abort_e, dq)));
  endtask

  task automatic sb_check(input evt_t act);
    evt_t e;
    checks++;
    $display("evt %s idx=%0d t0=%0d len=%0d pos=%0d", kname(act.kind), act.idx, act.t0, act.len, act.p);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected: got %s idx=%0d t0=%0d len=%0d pos=%0d, expected no event",
               kname(act.kind), act.idx, act.t0, act.len, act.p);
    end else begin
      e = exp_q.pop_front();
      if (act != e) begin
        errors++;
        $display("FAIL sb_%s: got %s idx=%0d t0=%0d len=%0d pos=%0d, expected %s idx=%0d t0=%0d len=%0d pos=%0d",
                 kname(e.kind), kname(act.kind), act.idx, act.t0, act.len, act.p,
                 kname(e.kind), e.idx, e.t0, e.len, e.p);
      end
    end
  endtask

  // Monitor: rebuilds events from pins on the falling edge.
  bit         v_open = 1'b0, b_open = 1'b0;
  int         v_idx, v_t0, v_len, v_pos, b_t0, b_len;
  logic [N:0] v_mask;
  always @(negedge clk) begin
    if (!rst_n || !sb_en) begin
      v_open = 1'b0;
      b_open = 1'b0;
    end else begin
      if (!$onehot0(valve)) begin
        checks++;
        errors++;
        $display("FAIL onehot_valve: got %b, expected at most one bit set", valve);
      end
      if (v_open) begin
        v_mask = '0;
        v_mask[v_idx] = 1'b1;
        if (valve != v_mask) begin
          sb_check(mk(0, v_idx, v_t0, v_len, v_pos));
          v_open = 1'b0;
        end
      end
      if (!v_open && valve != '0) begin
        for (int i = N; i >= 0; i--) if (valve[i]) v_idx = i;
        v_open = 1'b1; v_t0 = edge_cnt; v_len = 0; v_pos = int'(pos);
      end
      if (v_open) v_len++;
      if (b_open && !busy) begin
        sb_check(mk(1, 0, b_t0, b_len, 0));
        b_open = 1'b0;
      end
      if (!b_open && busy) begin
        b_open = 1'b1; b_t0 = edge_cnt; b_len = 0;
      end
      if (b_open) b_len++;
      if (done)    sb_check(mk(2, 0, edge_cnt, 1, int'(pos)));
      if (aborted) sb_check(mk(3, 0, edge_cnt, 1, int'(pos)));
    end
  end

  task automatic goto(input int k);
    int guard = 0;
    while (edge_cnt < k && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Called at a falling edge with the DUT idle; returns in an idle cycle.
  task automatic do_run(input int dw, input int abort_e, input bit poke);
    int a, dq, rl;
    dq = (dw == 0) ? 1 : dw;
    rl = P + N * (dq + P);
    a  = edge_cnt + 1;
    model_run(a, dq, abort_e);
    dwell = DW'(dw);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dwell = DW'($urandom);
    if (poke) begin
      goto(a + 3);
      start = 1'b1; dwell = DW'(9);
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_e >= 0) begin
      goto(a + abort_e);
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      chk("pos_hold_after_abort", int'(pos), pos_at(abort_e, dq));
    end else begin
      goto(a + rl);
      @(negedge clk);
      chk("pos_after_done", int'(pos), N);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dw, ae, pk, rl, a;
    repeat (3) @(negedge clk);
    chk("reset_valve", int'(valve), 0);
    chk("reset_pos", int'(pos), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_aborted", int'(aborted), 0);
    rst_n = 1'b1;
    @(negedge clk);
    sb_en = 1'b1;
    @(negedge clk);

    do_run(3, -1, 1'b1);          // start re-pulsed with dwell=9 is ignored
    do_run(3, -1, 1'b0);          // earliest restart right after DONE
    do_run(0, -1, 1'b0);          // dwell 0 behaves as 1
    do_run(3, P + 7 * (3 + P) + 3 + 1, 1'b0);  // abort mid-XFER at pos 7

    // abort together with start in IDLE: nothing starts, no aborted pulse
    start = 1'b1; abort = 1'b1; dwell = DW'(2);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle_busy", int'(busy), 0);
    chk("abort_start_idle_valve", int'(valve), 0);
    @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      dw = $urandom_range(0, 6);
      pk = $urandom_range(0, 1);
      rl = P + N * (((dw == 0) ? 1 : dw) + P);
      ae = ($urandom_range(0, 2) == 0) ? $urandom_range(pk ? 4 : 0, rl - 1) : -1;
      do_run(dw, ae, pk[0]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // asynchronous reset during XFER at pos 5
    sb_en = 1'b0;
    @(negedge clk);
    a = edge_cnt + 1;
    dwell = DW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    goto(a + P + 5 * (3 + P) + 3 + 1);
    chk("pre_reset_pos", int'(pos), 5);
    chk("pre_reset_valve", int'(valve), 1 << 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valve", int'(valve), 0);
    chk("async_reset_busy", int'(busy), 0);
    chk("async_reset_pos", int'(pos), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

`ifdef CHAIN_SEQ_STEP_EN
    step = 1'b0; dwell = DW'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("step_wait_busy", int'(busy), 1);
    chk("step_wait_valve", int'(valve), 0);
    chk("step_wait_pos", int'(pos), 0);
    step = 1'b1;
    @(negedge clk);
    chk("step_xfer_valve", int'(valve), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
`endif

    sb_en = 1'b1;
    @(negedge clk);
    do_run(1, -1, 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
